// File: rtl/loader_mem_scheduler_if.sv
// Loader / SDRAM-controller signal bundle for the ROM-load scheduler.
// master = scheduler side, slave = loader + controller side.
interface loader_mem_scheduler_if #(
  parameter int ADDR_W = 22
);

  logic              ld_write;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_refresh;
  logic              ld_done;
  logic              ld_error;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_refresh;
  logic              mem_ack;

  modport master (
    input  ld_write,
    input  ld_addr,
    input  ld_data,
    input  ld_refresh,
    input  ld_done,
    input  ld_error,
    input  mem_ack,
    output mem_req,
    output mem_addr,
    output mem_din,
    output mem_refresh
  );

  modport slave (
    output ld_write,
    output ld_addr,
    output ld_data,
    output ld_refresh,
    output ld_done,
    output ld_error,
    output mem_ack,
    input  mem_req,
    input  mem_addr,
    input  mem_din,
    input  mem_refresh
  );

endinterface

// File: rtl/loader_mem_scheduler.sv
// ROM-load SDRAM port scheduler: buffers loader bytes, issues writes and
// refreshes over req/ack, then hands memory to the console.
module loader_mem_scheduler #(
  parameter int FIFO_DEPTH       = 4,
  parameter int REFRESH_INTERVAL = 750,
  parameter int ADDR_W           = 22
) (
  input  logic                         clk,
  input  logic                         reset,
  loader_mem_scheduler_if.master       bus,
  output logic                         run_enable,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int EW = ADDR_W + 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    REFRESH,
    RUN,
    ERROR
  } state_t;

  state_t state;
  state_t state_d;

  logic [EW-1:0] buffer [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;

  logic [TW-1:0] timer;
  logic          refresh_pending;

  logic empty;
  logic full;
  logic active;
  logic accept;
  logic flush;
  logic push;
  logic pop;
  logic drop;
  logic ack_write;
  logic ack_refresh;
  logic timer_sat;

  // Handshake decode and FIFO push/pop/drop qualification
  always_comb begin
    empty       = (count == '0);
    full        = (count == CW'(FIFO_DEPTH));
    active      = (state != RUN) && (state != ERROR);
    ack_write   = (state == WRITE) && bus.mem_ack;
    ack_refresh = (state == REFRESH) && bus.mem_ack;
    timer_sat   = (timer == TW'(REFRESH_INTERVAL - 1));
    flush       = (state_d == ERROR);
    accept      = bus.ld_write && active && !flush;
    pop         = ack_write;
    push        = accept && (!full || pop);
    drop        = accept && full && !pop;
    head        = buffer[rd_ptr];
  end

  // Next-state: error first, then refresh, then writes, then hand-off
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.ld_error)
          state_d = ERROR;
        else if (refresh_pending)
          state_d = REFRESH;
        else if (!empty)
          state_d = WRITE;
        else if (bus.ld_done && empty)
          state_d = RUN;
      end
      WRITE: begin
        if (bus.mem_ack)
          state_d = bus.ld_error ? ERROR : IDLE;
      end
      REFRESH: begin
        if (bus.mem_ack)
          state_d = bus.ld_error ? ERROR : IDLE;
      end
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  // Buffer storage; head slot is only read while occupied
  always_ff @(posedge clk) begin
    if (push)
      buffer[wr_ptr] <= {bus.ld_addr, bus.ld_data};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
    end
  end

  // Refresh timer and pending flag; a finished refresh absorbs requests
  always_ff @(posedge clk) begin
    if (reset) begin
      timer           <= '0;
      refresh_pending <= 1'b0;
    end else if (ack_refresh) begin
      timer           <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (active && !timer_sat)
        timer <= timer + TW'(1);
      if ((active && timer_sat) || bus.ld_refresh)
        refresh_pending <= 1'b1;
    end
  end

  // Outputs decoded from state; bus zeroed outside WRITE
  always_comb begin
    bus.mem_req     = (state == WRITE);
    bus.mem_refresh = (state == REFRESH);
    run_enable      = (state == RUN);
    fifo_level      = count;
    bus.mem_addr    = '0;
    bus.mem_din     = '0;
    if (state == WRITE) begin
      bus.mem_addr = head[EW-1:8];
      bus.mem_din  = head[7:0];
    end
  end

endmodule

// File: tb/tb_loader_mem_scheduler.sv
// Directed bench for loader_mem_scheduler with a responding
// controller model and an in-order write scoreboard.
module tb_loader_mem_scheduler;

  localparam int ADDR_W = 22;
  localparam int DEPTH  = 4;
  localparam int RI     = 750;
  localparam int EW     = ADDR_W + 8;
  localparam int EV_W   = 1;
  localparam int EV_R   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_enable;
  logic       overflow;
  logic [2:0] fifo_level;

  loader_mem_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  loader_mem_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .REFRESH_INTERVAL(RI),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .run_enable(run_enable),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  int ev_q[$];
  bit ack_en = 1'b0;
  int ack_delay = 1;
  bit started = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    ack_en         = 1'b0;
    bus.ld_write   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_refresh = 1'b0;
    bus.ld_done    = 1'b0;
    bus.ld_error   = 1'b0;
    reset          = 1'b1;
    cyc(2);
    reset = 1'b0;
    exp_q.delete();
    ev_q.delete();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                    input bit accepted);
    bus.ld_write = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    if (accepted)
      exp_q.push_back({a, d});
    cyc(1);
    bus.ld_write = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.mem_req || bus.mem_refresh)
           && n < max) begin
      cyc(1);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < max), 32'd1);
  endtask

  // Controller model: acks after ack_delay request cycles, scores writes
  initial begin
    int wait_cnt;
    logic [EW-1:0] held;
    logic [EW-1:0] e;
    wait_cnt    = 0;
    held        = '0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (started && !bus.mem_req) begin
        chk("addr_idle", 32'(bus.mem_addr), 32'd0);
        chk("din_idle", 32'(bus.mem_din), 32'd0);
      end
      if (bus.mem_req || bus.mem_refresh) begin
        if (bus.mem_req) begin
          if (wait_cnt == 0)
            held = {bus.mem_addr, bus.mem_din};
          else
            chk("req_stable", 32'({bus.mem_addr, bus.mem_din}), 32'(held));
        end
        wait_cnt++;
        if (ack_en && wait_cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          wait_cnt    = 0;
          if (bus.mem_req) begin
            ev_q.push_back(EV_W);
            if (exp_q.size() == 0) begin
              chk("unexpected_write", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("write_data", 32'({bus.mem_addr, bus.mem_din}), 32'(e));
            end
          end else begin
            ev_q.push_back(EV_R);
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    int n;

    // Reset state
    do_reset();
    started = 1'b1;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_refresh", 32'(bus.mem_refresh), 32'd0);
    chk("rst_run", 32'(run_enable), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);

    // 1: single write, latency N+2, ack 3 cycles into request
    ack_en    = 1'b1;
    ack_delay = 3;
    wr(22'h000010, 8'hA5, 1'b1);
    chk("t1_level1", 32'(fifo_level), 32'd1);
    chk("t1_req_n1", 32'(bus.mem_req), 32'd0);
    cyc(1);
    chk("t1_req_n2", 32'(bus.mem_req), 32'd1);
    chk("t1_addr", 32'(bus.mem_addr), 32'h10);
    chk("t1_din", 32'(bus.mem_din), 32'hA5);
    cyc(2);
    chk("t1_req_hold", 32'(bus.mem_req), 32'd1);
    cyc(1);
    chk("t1_req_drop", 32'(bus.mem_req), 32'd0);
    chk("t1_level0", 32'(fifo_level), 32'd0);
    chk("t1_sb", 32'(exp_q.size()), 32'd0);

    // 2: five-byte burst with acks held off; fifth byte dropped
    do_reset();
    ack_delay = 1;
    for (int i = 0; i < 5; i++)
      wr(22'h000100 + 22'(i), 8'h30 + 8'(i), i < DEPTH);
    chk("t2_level", 32'(fifo_level), 32'd4);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_head", 32'(bus.mem_addr), 32'h100);
    ack_en = 1'b1;
    wait_drain("t2", 40);
    chk("t2_writes", 32'(ev_q.size()), 32'd4);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);
    chk("t2_level0", 32'(fifo_level), 32'd0);

    // 3: timer-forced refresh; counts RI-1 cycles, flags, then issues
    do_reset();
    ack_en    = 1'b1;
    ack_delay = 2;
    n = 0;
    while (!bus.mem_refresh && n < RI + 10) begin
      cyc(1);
      n++;
    end
    chk("t3_first", 32'(n), 32'(RI + 1));
    n = 0;
    while (bus.mem_refresh && n < 10) begin
      cyc(1);
      n++;
    end
    chk("t3_ack", 32'(n < 10), 32'd1);
    n = 0;
    while (!bus.mem_refresh && n < RI + 10) begin
      cyc(1);
      n++;
    end
    chk("t3_second", 32'(n), 32'(RI + 1));
    cyc(3);
    chk("t3_count", 32'(ev_q.size()), 32'd2);

    // 4: refresh request during a write is serviced before the next write
    do_reset();
    ack_en    = 1'b1;
    ack_delay = 4;
    wr(22'h000200, 8'h11, 1'b1);
    wr(22'h000201, 8'h22, 1'b1);
    chk("t4_inflight", 32'(bus.mem_req), 32'd1);
    bus.ld_refresh = 1'b1;
    cyc(1);
    bus.ld_refresh = 1'b0;
    wait_drain("t4", 60);
    chk("t4_n", 32'(ev_q.size()), 32'd3);
    if (ev_q.size() == 3) begin
      chk("t4_ev0", 32'(ev_q[0]), 32'(EV_W));
      chk("t4_ev1", 32'(ev_q[1]), 32'(EV_R));
      chk("t4_ev2", 32'(ev_q[2]), 32'(EV_W));
    end
    bus.ld_refresh = 1'b1;
    cyc(1);
    bus.ld_refresh = 1'b0;
    cyc(2);
    chk("t4_ref_on", 32'(bus.mem_refresh), 32'd1);
    bus.ld_refresh = 1'b1;
    cyc(1);
    bus.ld_refresh = 1'b0;
    cyc(15);
    chk("t4_absorb", 32'(ev_q.size()), 32'd4);

    // 5: drain on ld_done, then console owns memory
    do_reset();
    ack_delay = 2;
    for (int i = 0; i < 3; i++)
      wr(22'h000300 + 22'(i), 8'h50 + 8'(i), 1'b1);
    chk("t5_level", 32'(fifo_level), 32'd3);
    bus.ld_done = 1'b1;
    cyc(2);
    chk("t5_run_early", 32'(run_enable), 32'd0);
    ack_en = 1'b1;
    n = 0;
    while (!run_enable && n < 50) begin
      cyc(1);
      n++;
    end
    chk("t5_run", 32'(run_enable), 32'd1);
    chk("t5_sb", 32'(exp_q.size()), 32'd0);
    chk("t5_writes", 32'(ev_q.size()), 32'd3);
    for (int i = 0; i < 6; i++)
      wr(22'h000400 + 22'(i), 8'h77, 1'b0);
    cyc(2);
    chk("t5_ign_level", 32'(fifo_level), 32'd0);
    chk("t5_ign_ovf", 32'(overflow), 32'd0);
    chk("t5_ign_req", 32'(bus.mem_req), 32'd0);
    chk("t5_run_stay", 32'(run_enable), 32'd1);

    // 6: error mid-write waits for ack, then flushes and idles
    do_reset();
    ack_delay = 1;
    wr(22'h000500, 8'h01, 1'b1);
    wr(22'h000501, 8'h02, 1'b1);
    bus.ld_error = 1'b1;
    cyc(3);
    chk("t6_held", 32'(bus.mem_req), 32'd1);
    chk("t6_level2", 32'(fifo_level), 32'd2);
    ack_en = 1'b1;
    cyc(2);
    chk("t6_flushed_sb", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    chk("t6_level0", 32'(fifo_level), 32'd0);
    chk("t6_req_off", 32'(bus.mem_req), 32'd0);
    bus.ld_error = 1'b0;
    wr(22'h000600, 8'h03, 1'b0);
    cyc(10);
    chk("t6_no_req", 32'(bus.mem_req | bus.mem_refresh), 32'd0);
    chk("t6_writes", 32'(ev_q.size()), 32'd1);
    chk("t6_level_stay", 32'(fifo_level), 32'd0);

    // 6b: reset while busy clears every output within one cycle
    do_reset();
    for (int i = 0; i < 5; i++)
      wr(22'h000700 + 22'(i), 8'h90 + 8'(i), 1'b0);
    chk("t6b_busy", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    cyc(1);
    chk("t6b_req", 32'(bus.mem_req), 32'd0);
    chk("t6b_addr", 32'(bus.mem_addr), 32'd0);
    chk("t6b_din", 32'(bus.mem_din), 32'd0);
    chk("t6b_ref", 32'(bus.mem_refresh), 32'd0);
    chk("t6b_ovf", 32'(overflow), 32'd0);
    chk("t6b_level", 32'(fifo_level), 32'd0);
    chk("t6b_run", 32'(run_enable), 32'd0);
    reset = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
